// File: rtl/sap_cpu_param_if.sv
// Bus interface for sap_cpu_param: program-load port, output register and
// debug taps. The CPU takes the slave modport; the driver of step_en and
// the program port takes the master modport.
interface sap_cpu_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              step_en;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [ADDR_W-1:0] pc_dbg;
    logic [DATA_W-1:0] a_dbg;
    logic [1:0]        flags_dbg;

    modport master (
        output step_en, prog_we, prog_addr, prog_data,
        input  out_data, out_valid, halted, pc_dbg, a_dbg, flags_dbg
    );

    modport slave (
        input  step_en, prog_we, prog_addr, prog_data,
        output out_data, out_valid, halted, pc_dbg, a_dbg, flags_dbg
    );
endinterface

// File: rtl/sap_cpu_param.sv
// Parametrised multi-cycle accumulator CPU with a shared internal bus,
// unified program/data RAM and a microstep sequencer advanced by step_en.
// Optional macro SAP_CPU_CALL_EN adds single-level CAL (opcode A) and
// RTN (opcode B); without it both execute as NOP.
//
// step | meaning
// T0   | MAR <= PC
// T1   | IR <= RAM[MAR], PC <= PC+1
// T2   | first execute step (all opcodes)
// T3   | second execute step (LDA, ADD, STA, SUB)
// T4   | ALU writeback and flags (ADD, SUB)
module sap_cpu_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic            clk,
    input logic            reset,
    sap_cpu_param_if.slave io
);
    localparam int PAD = DATA_W - ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_SUB = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;
`ifdef SAP_CPU_CALL_EN
    localparam logic [3:0] OP_CAL = 4'hA;
    localparam logic [3:0] OP_RTN = 4'hB;
`endif

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    step_t             step, step_nxt;
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] a, b, ir, out_data, bus, alu;
    logic              c, z, c_nxt, halted, run;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
`ifdef SAP_CPU_CALL_EN
    logic [ADDR_W-1:0] ret;
`endif

    assign opcode  = ir[DATA_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];
    assign run     = io.step_en && !halted;
    assign sum     = {1'b0, a} + {1'b0, b};

    // ALU: SUB carry means "no borrow", i.e. A >= B
    always_comb begin
        alu   = sum[DATA_W-1:0];
        c_nxt = sum[DATA_W];
        if (opcode == OP_SUB) begin
            alu   = a - b;
            c_nxt = (a >= b);
        end
    end

    // Bus source select: exactly one driver per microstep
    always_comb begin
        bus = '0;
        case (step)
            T0: bus = {{PAD{1'b0}}, pc};
            T1: bus = mem[mar];
            T2: begin
                bus = {{PAD{1'b0}}, operand};
                if (opcode == OP_OUT) bus = a;
`ifdef SAP_CPU_CALL_EN
                if (opcode == OP_RTN) bus = {{PAD{1'b0}}, ret};
`endif
            end
            T3: bus = (opcode == OP_STA) ? a : mem[mar];
            T4: bus = alu;
            default: bus = '0;
        endcase
    end

    // Microstep register; halted parks the sequencer at T0
    always_ff @(posedge clk) begin
        if (reset)    step <= T0;
        else if (run) step <= step_nxt;
    end

    // Microstep sequencing: instruction length depends on opcode
    always_comb begin
        step_nxt = T0;
        case (step)
            T0: step_nxt = T1;
            T1: step_nxt = T2;
            T2: step_nxt = (opcode == OP_LDA || opcode == OP_ADD ||
                            opcode == OP_STA || opcode == OP_SUB) ? T3 : T0;
            T3: step_nxt = (opcode == OP_ADD || opcode == OP_SUB) ? T4 : T0;
            default: step_nxt = T0;
        endcase
    end

    // Datapath registers loaded from the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            mar      <= '0;
            a        <= '0;
            b        <= '0;
            ir       <= '0;
            c        <= 1'b0;
            z        <= 1'b0;
            out_data <= '0;
            halted   <= 1'b0;
        end else if (run) begin
            case (step)
                T0: mar <= bus[ADDR_W-1:0];
                T1: begin
                    ir <= bus;
                    pc <= pc + PC_ONE;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_STA, OP_SUB: mar <= bus[ADDR_W-1:0];
                        OP_OUT: out_data <= bus;
                        OP_JMP: pc <= bus[ADDR_W-1:0];
                        OP_LDI: a <= bus;
                        OP_JC:  if (c) pc <= bus[ADDR_W-1:0];
                        OP_JZ:  if (z) pc <= bus[ADDR_W-1:0];
                        OP_HLT: halted <= 1'b1;
`ifdef SAP_CPU_CALL_EN
                        OP_CAL, OP_RTN: pc <= bus[ADDR_W-1:0];
`endif
                        default: ;
                    endcase
                end
                T3: begin
                    if (opcode == OP_LDA) a <= bus;
                    if (opcode == OP_ADD || opcode == OP_SUB) b <= bus;
                end
                T4: begin
                    a <= bus;
                    c <= c_nxt;
                    z <= (bus == '0);
                end
                default: ;
            endcase
        end
    end

`ifdef SAP_CPU_CALL_EN
    // Single-level return register; a nested CAL overwrites it
    always_ff @(posedge clk) begin
        if (reset)
            ret <= '0;
        else if (run && step == T2 && opcode == OP_CAL)
            ret <= pc;
    end
`endif

    // RAM: program port only while stopped, STA write dropped under reset
    always_ff @(posedge clk) begin
        if (io.prog_we && (reset || halted))
            mem[io.prog_addr] <= io.prog_data;
        else if (!reset && run && step == T3 && opcode == OP_STA)
            mem[mar] <= bus;
    end

    // out_valid spans the clk whose closing edge loads out_data
    assign io.out_valid = !reset && run && step == T2 && opcode == OP_OUT;
    assign io.out_data  = out_data;
    assign io.halted    = halted;
    assign io.pc_dbg    = pc;
    assign io.a_dbg     = a;
    assign io.flags_dbg = {c, z};
endmodule

// File: tb/tb_sap_cpu_param.sv
// Testbench for sap_cpu_param: directed programs plus random straight-line
// programs, all checked against an instruction-level reference model.
module tb_sap_cpu_param;
    logic clk = 1'b0;
    logic reset, reset2;
    always #5 clk = ~clk;

    sap_cpu_param_if #(.DATA_W(8), .ADDR_W(4)) ifc ();
    sap_cpu_param #(.DATA_W(8), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .io(ifc));

    sap_cpu_param_if #(.DATA_W(12), .ADDR_W(8)) ifw ();
    sap_cpu_param #(.DATA_W(12), .ADDR_W(8)) dutw (.clk(clk), .reset(reset2), .io(ifw));

    int errors = 0;
    int checks = 0;

    logic [7:0] prog [16];
    int m_out[$];
    int m_a, m_c, m_z, m_pc, m_cyc;
    bit m_halt;
    int d_out[$];
    int d_cyc, d_tot, unstable;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference: each opcode's effect and its clk count
    task automatic model();
        int mm[16];
        int ins, opc, opd, t;
        foreach (mm[i]) mm[i] = int'(prog[i]);
        m_pc = 0; m_a = 0; m_c = 0; m_z = 0; m_cyc = 0; m_halt = 0;
        m_out.delete();
        for (int n = 0; n < 500 && !m_halt; n++) begin
            ins = mm[m_pc]; opc = ins / 16; opd = ins % 16;
            m_pc = (m_pc + 1) % 16;
            case (opc)
                1: begin m_a = mm[opd]; m_cyc += 4; end
                2: begin t = m_a + mm[opd]; m_c = int'(t > 255); m_a = t % 256;
                         m_z = int'(m_a == 0); m_cyc += 5; end
                3: begin m_out.push_back(m_a); m_cyc += 3; end
                4: begin m_pc = opd; m_cyc += 3; end
                5: begin mm[opd] = m_a; m_cyc += 4; end
                6: begin m_a = opd; m_cyc += 3; end
                7: begin m_c = int'(m_a >= mm[opd]); m_a = (m_a - mm[opd] + 256) % 256;
                         m_z = int'(m_a == 0); m_cyc += 5; end
                8: begin if (m_c != 0) m_pc = opd; m_cyc += 3; end
                9: begin if (m_z != 0) m_pc = opd; m_cyc += 3; end
                15: begin m_halt = 1; m_cyc += 3; end
                default: m_cyc += 3;
            endcase
        end
    endtask

    task automatic tick(input bit en, input bit rst);
        logic v;
        @(negedge clk);
        ifc.step_en = en;
        ifc.prog_we = 1'b0;
        reset = rst;
        #1;
        v = ifc.out_valid;
        if (!en && v) unstable++;
        @(posedge clk);
        #1;
        if (v) d_out.push_back(int'(ifc.out_data));
        d_tot++;
        if (en && !rst) d_cyc++;
    endtask

    task automatic write_word(input int addr, input logic [7:0] data);
        @(negedge clk);
        reset = 1'b1;
        ifc.step_en = 1'b0;
        ifc.prog_we = 1'b1;
        ifc.prog_addr = 4'(addr);
        ifc.prog_data = data;
    endtask

    task automatic load();
        for (int i = 0; i < 16; i++) write_word(i, prog[i]);
        @(negedge clk);
        ifc.prog_we = 1'b0;
    endtask

    // mode 0: step_en always high; 1: toggling starting low; 2: random
    task automatic run(input int mode);
        bit en;
        logic [31:0] snap;
        d_out.delete();
        d_cyc = 0; d_tot = 0; unstable = 0;
        do begin
            case (mode)
                0: en = 1'b1;
                1: en = d_tot[0];
                default: en = 1'($urandom_range(0, 1));
            endcase
            snap = {9'd0, ifc.out_data, ifc.pc_dbg, ifc.a_dbg, ifc.flags_dbg, ifc.halted};
            tick(en, 1'b0);
            if (!en && snap != {9'd0, ifc.out_data, ifc.pc_dbg, ifc.a_dbg, ifc.flags_dbg, ifc.halted})
                unstable++;
        end while (!ifc.halted && d_tot < 3000);
        check("halt_reached", 32'(ifc.halted), 32'd1);
        check("stable_when_idle", 32'(unstable), 32'd0);
    endtask

    task automatic compare(input string tag);
        int n;
        model();
        check({tag, "_cycles"}, 32'(d_cyc), 32'(m_cyc));
        check({tag, "_nout"}, 32'(d_out.size()), 32'(m_out.size()));
        n = (d_out.size() < m_out.size()) ? d_out.size() : m_out.size();
        for (int i = 0; i < n; i++) check({tag, "_out"}, 32'(d_out[i]), 32'(m_out[i]));
        check({tag, "_a"}, 32'(ifc.a_dbg), 32'(m_a));
        check({tag, "_flags"}, 32'(ifc.flags_dbg), 32'(m_c * 2 + m_z));
        check({tag, "_pc"}, 32'(ifc.pc_dbg), 32'(m_pc));
    endtask

    task automatic set_prog1();
        foreach (prog[i]) prog[i] = 8'h00;
        prog[0] = 8'h63; prog[1] = 8'h2F; prog[2] = 8'h30; prog[3] = 8'hF0; prog[15] = 8'h05;
    endtask

    initial begin
        int ops[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 13, 14};
        int op, opd, steps;

        reset = 1'b1; reset2 = 1'b1;
        ifc.step_en = 1'b0; ifc.prog_we = 1'b0; ifc.prog_addr = '0; ifc.prog_data = '0;
        ifw.step_en = 1'b0; ifw.prog_we = 1'b0; ifw.prog_addr = '0; ifw.prog_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", 32'(ifc.pc_dbg), 32'd0);
        check("reset_a", 32'(ifc.a_dbg), 32'd0);
        check("reset_flags", 32'(ifc.flags_dbg), 32'd0);
        check("reset_halted", 32'(ifc.halted), 32'd0);
        check("reset_valid", 32'(ifc.out_valid), 32'd0);

        // LDI 3; ADD F; OUT; HLT; F=5
        set_prog1(); load(); run(0);
        compare("t1");
        check("t1_out_08", 32'(d_out.size() > 0 ? d_out[0] : -1), 32'h08);
        check("t1_14clk", 32'(d_cyc), 32'd14);

        // 0xFF + 0x01 carries to zero; JC taken to OUT
        foreach (prog[i]) prog[i] = 8'h00;
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h84; prog[3] = 8'hF0;
        prog[4] = 8'h30; prog[5] = 8'hF0; prog[14] = 8'hFF; prog[15] = 8'h01;
        load(); run(0);
        compare("t2");
        check("t2_flags_11", 32'(ifc.flags_dbg), 32'd3);
        check("t2_pc_after_jc", 32'(ifc.pc_dbg), 32'd6);

        // 5 - 7: no carry, no zero; JC and JZ fall through
        foreach (prog[i]) prog[i] = 8'h00;
        prog[0] = 8'h65; prog[1] = 8'h7F; prog[2] = 8'h86; prog[3] = 8'h96;
        prog[4] = 8'h30; prog[5] = 8'hF0; prog[6] = 8'hF0; prog[15] = 8'h07;
        load();
        d_out.delete(); d_cyc = 0; d_tot = 0;
        for (int i = 0; i < 11; i++) tick(1'b1, 1'b0);
        check("t3_pc_after_jc", 32'(ifc.pc_dbg), 32'd3);
        check("t3_a_fe", 32'(ifc.a_dbg), 32'hFE);
        check("t3_flags_00", 32'(ifc.flags_dbg), 32'd0);
        run(0);
        check("t3_out_fe", 32'(d_out.size() > 0 ? d_out[0] : -1), 32'hFE);

        // Test 1 with step_en toggling every clk
        set_prog1(); load(); run(1);
        compare("t4");
        check("t4_28clk", 32'(d_tot), 32'd28);

        // Reset during T3 of ADD, then rerun
        set_prog1(); load();
        d_out.delete(); d_cyc = 0; d_tot = 0;
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        check("t5_pre_a", 32'(ifc.a_dbg), 32'd3);
        tick(1'b1, 1'b1);
        check("t5_add_pc", 32'(ifc.pc_dbg), 32'd0);
        check("t5_add_a", 32'(ifc.a_dbg), 32'd0);
        check("t5_add_halted", 32'(ifc.halted), 32'd0);
        run(0);
        compare("t5_rerun");

        // Reset during T3 of STA leaves the target word intact
        foreach (prog[i]) prog[i] = 8'h00;
        prog[0] = 8'h69; prog[1] = 8'h5E; prog[2] = 8'hF0; prog[14] = 8'h33;
        load();
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        check("t5_sta_pc", 32'(ifc.pc_dbg), 32'd0);
        check("t5_sta_a", 32'(ifc.a_dbg), 32'd0);
        prog[0] = 8'h1E; prog[1] = 8'h30; prog[2] = 8'hF0;
        for (int i = 0; i < 3; i++) write_word(i, prog[i]);
        run(0);
        compare("t5_sta");
        check("t5_sta_word", 32'(d_out.size() > 0 ? d_out[0] : -1), 32'h33);

        // Random straight-line programs with forward-only jumps
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 10; i++) begin
                op = ops[$urandom_range(0, 12)];
                case (op)
                    1, 2, 5, 7: opd = $urandom_range(11, 15);
                    4, 8, 9:    opd = $urandom_range(i + 1, 10);
                    default:    opd = $urandom_range(0, 15);
                endcase
                prog[i] = 8'(op * 16 + opd);
            end
            prog[10] = 8'hF0;
            for (int i = 11; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
            load(); run(r % 3);
            compare("rand");
        end

        // Wide build: PC wraps from 0xFF to 0x00
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            ifw.prog_we = 1'b1; ifw.prog_addr = 8'(i);
            ifw.prog_data = (i == 0) ? 12'h4C0 : 12'h000;
        end
        @(negedge clk);
        ifw.prog_we = 1'b0; reset2 = 1'b0; ifw.step_en = 1'b1;
        repeat (192) @(posedge clk);
        #1 check("t6_pc_ff", 32'(ifw.pc_dbg), 32'hFF);
        repeat (3) @(posedge clk);
        #1 check("t6_pc_wrap", 32'(ifw.pc_dbg), 32'h00);

        // CAL/RTN (or NOPs without the call feature)
        @(negedge clk);
        reset2 = 1'b1; ifw.step_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ifw.prog_we = 1'b1;
            case (i)
                0: begin ifw.prog_addr = 8'h00; ifw.prog_data = 12'h410; end
                1: begin ifw.prog_addr = 8'h10; ifw.prog_data = 12'hA40; end
                2: begin ifw.prog_addr = 8'h40; ifw.prog_data = 12'hB00; end
                default: begin ifw.prog_addr = 8'h11; ifw.prog_data = 12'hF00; end
            endcase
        end
        @(negedge clk);
        ifw.prog_we = 1'b0; reset2 = 1'b0; ifw.step_en = 1'b1;
        repeat (6) @(posedge clk);
`ifdef SAP_CPU_CALL_EN
        #1 check("t6_cal_pc", 32'(ifw.pc_dbg), 32'h40);
`else
        #1 check("t6_cal_pc", 32'(ifw.pc_dbg), 32'h11);
`endif
        steps = 6;
        while (!ifw.halted && steps < 200) begin
            @(posedge clk);
            #1 steps++;
        end
        check("t6_halted", 32'(ifw.halted), 32'd1);
        check("t6_ret_pc", 32'(ifw.pc_dbg), 32'h12);
`ifdef SAP_CPU_CALL_EN
        check("t6_clks", 32'(steps), 32'd12);
`else
        check("t6_clks", 32'(steps), 32'd9);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sap_cpu_param.md
Name: sap_cpu_param

Overview:
Parametrised multi-cycle accumulator CPU with a shared internal bus, unified program/data RAM, and a microstep sequencer. It replaces the fixed 8-bit/16-word core with configurable data and address widths, carry/zero flags, conditional jumps, SUB, HLT and an external program-load port. The core runs on the system clock with a step-enable strobe instead of a derived clock, and feeds the board output display.

Parameters:
DATA_W, 8, data/instruction word width; opcode = instr[DATA_W-1 -: 4], operand = instr[ADDR_W-1:0]; DATA_W >= ADDR_W+4 is required
ADDR_W, 4, RAM address width; depth = 2^ADDR_W words

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
step_en  in  1  advances one microstep per clk when high; all state frozen when low
prog_we  in  1  RAM write strobe, honoured only while reset=1 or halted=1
prog_addr  in  ADDR_W  program-load address
prog_data  in  DATA_W  program-load data
out_data  out  DATA_W  output register
out_valid  out  1  one-clk pulse when out_data is written
halted  out  1  high after HLT until reset
pc_dbg  out  ADDR_W  current PC
a_dbg  out  DATA_W  accumulator
flags_dbg  out  2  {C,Z}

Behaviour:
- Reset (sync, has priority over everything except prog_we): PC, A, B, IR, MAR, return register, C, Z, out_data, out_valid, halted = 0; microstep = T0. RAM is not cleared. Reset during any microstep aborts the instruction; the pending RAM write is dropped.
- Microsteps consume one clk with step_en=1. T0: MAR<=PC. T1: IR<=RAM[MAR], PC<=PC+1 mod 2^ADDR_W. Execute steps follow. After the last step, the next enabled clk is T0.
- Opcodes and execute steps:
  - 0 NOP: T2 nothing (3 steps).
  - 1 LDA: T2 MAR<=op; T3 A<=RAM (4 steps).
  - 2 ADD: T2 MAR<=op; T3 B<=RAM; T4 A<=A+B mod 2^DATA_W, C=carry-out, Z=(result==0) (5 steps).
  - 3 OUT: T2 out_data<=A, out_valid=1 for that clk only (3 steps).
  - 4 JMP: T2 PC<=op (3 steps).
  - 5 STA: T2 MAR<=op; T3 RAM[MAR]<=A (4 steps).
  - 6 LDI: T2 A<=zero-extended op (3 steps).
  - 7 SUB: as ADD, but A<=A-B, C=1 iff A>=B (no borrow) (5 steps).
  - 8 JC: T2 PC<=op if C=1, else no change (3 steps).
  - 9 JZ: T2 PC<=op if Z=1, else no change (3 steps).
  - F HLT: T2 halted<=1; the sequencer stops at T0 and ignores step_en until reset.
  - A/B: see Optional Feature. C-E: executed as NOP.
- Flags change only in T4 of ADD/SUB.
- out_valid is 0 whenever step_en=0.
- prog_we with reset=1 or halted=1: RAM[prog_addr]<=prog_data on that clk. prog_we at any other time is ignored.
- Bus priority is single-driver by construction. Exactly one source is selected per microstep.

Optional Feature:
- Macro: SAP_CPU_CALL_EN.
- Defined: opcode A CAL does T2 RET<=PC (already incremented), PC<=op (3 steps). Opcode B RTN does T2 PC<=RET (3 steps). The return register is single-level; a nested CAL overwrites it.
- Undefined: A and B execute as NOP; the return register is not instantiated.

Test Plan:
1. Load via prog port under reset: 0:LDI 3, 1:ADD F, 2:OUT, 3:HLT, F:0x05. Release reset with step_en=1 -> one out_valid pulse with out_data=0x08; halted=1 after exactly 14 enabled clks; flags {C,Z}=00.
2. A=0xFF from RAM, ADD word holding 0x01, then JC to OUT -> A=0x00, flags=11, jump taken, out_data=0x00.
3. A=5, SUB word holding 7, then JC -> A=0xFE, flags=00, branch not taken, PC = JC address+1; a following JZ is also not taken.
4. Repeat test 1 with step_en toggling 1/0 every clk -> identical out_data sequence; halted after 28 clks; all outputs stable while step_en=0.
5. Assert reset during T3 of an ADD, and during T3 of STA -> next clk pc_dbg=0, a_dbg=0, halted=0. The STA target word is unchanged. The program reruns to the same result as test 1.
6. DATA_W=12, ADDR_W=8: JMP 0xC0, run NOPs to 0xFF -> PC wraps to 0x00. With SAP_CPU_CALL_EN, CAL 0x40 at 0x10 followed by RTN returns to 0x11; without it, CAL/RTN behave as NOP.
